screen_mem_arbiter: RTL and testbench

//  Single-port RAM arbiter serving the screen-read requests issued by vga_render.

---
 rtl/screen_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_screen_mem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/screen_mem_arbiter.sv
// screen_mem_arbiter
//   Shares a single-port synchronous RAM between the vga_render screen reader
//   and the 6502 core. Render always wins the port; the CPU is paused through
//   RDY while render holds it, and its read data is held stable across the
//   pause. CPU addresses above the RAM window read as OOB_DATA and writes
//   there are dropped.
//
// Optional feature macro: RANDOM_REG_EN
//   When defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'h01) runs
//   every clock and CPU reads of RAND_ADDR return its value instead of RAM.
//   CPU writes to RAND_ADDR still reach RAM.
//
// Ports
//   clk               system clock
//   reset             asynchronous active-high reset
//   screen_read_en    render request, granted in the same cycle
//   screen_read_addr  render read address
//   screen_read_data  render read data (RAM pass-through)
//   screen_read_valid render data valid, one cycle after the request
//   cpu_addr/cpu_we/cpu_dout  CPU bus from the core
//   cpu_din           CPU read data (held across stalls)
//   cpu_rdy           CPU RDY, 0 pauses the core
//   ram_addr/ram_we/ram_wdata/ram_rdata  RAM port (1-cycle read latency)
//   stall_cnt         saturating count of CPU stall cycles

module screen_mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 11,
   parameter logic [7:0]  OOB_DATA   = 8'hFF,
   parameter logic [15:0] RAND_ADDR  = 16'h00FE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  screen_read_en,
   input  logic [ADDR_WIDTH-1:0] screen_read_addr,
   output logic [7:0]            screen_read_data,
   output logic                  screen_read_valid,
   input  logic [15:0]           cpu_addr,
   input  logic                  cpu_we,
   input  logic [7:0]            cpu_dout,
   output logic [7:0]            cpu_din,
   output logic                  cpu_rdy,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [7:0]            ram_wdata,
   input  logic [7:0]            ram_rdata,
   output logic [15:0]           stall_cnt
);

   logic        render_gnt;
   logic        cpu_gnt;
   logic        in_ram;

   logic        r_render_q, r_render_d;
   logic        r_cpurd_q,  r_cpurd_d;
   logic        r_oob_q,    r_oob_d;
   logic [7:0]  hold_q,     hold_d;
   logic [15:0] stall_q,    stall_d;
   logic [7:0]  rd_sel;

`ifdef RANDOM_REG_EN
   logic        r_rand_q,   r_rand_d;
   logic [7:0]  lfsr_q,     lfsr_d;
   logic [7:0]  rand_q,     rand_d;
`else
   logic        unused_rand_addr;
   assign unused_rand_addr = ^RAND_ADDR;
`endif

   // Grant: render owns the port whenever it asks; reset also blocks the CPU
   // so no RAM write can slip out while reset is asserted.
   assign render_gnt = screen_read_en;
   assign cpu_gnt    = ~screen_read_en & ~reset;
   assign in_ram     = (cpu_addr >> ADDR_WIDTH) == 16'd0;

   assign cpu_rdy           = cpu_gnt;
   assign ram_addr          = render_gnt ? screen_read_addr : cpu_addr[ADDR_WIDTH-1:0];
   assign ram_we            = cpu_gnt & cpu_we & in_ram;
   assign ram_wdata         = cpu_dout;
   assign screen_read_data  = ram_rdata;
   assign screen_read_valid = r_render_q;
   assign stall_cnt         = stall_q;

   always_comb begin
      r_render_d = render_gnt;
      r_cpurd_d  = cpu_gnt & ~cpu_we;
      r_oob_d    = ~in_ram;

      // Read data source for the phase following a CPU read grant
      rd_sel = r_oob_q ? OOB_DATA : ram_rdata;
`ifdef RANDOM_REG_EN
      r_rand_d = (cpu_addr == RAND_ADDR);
      lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      // Snapshot of the LFSR as seen during the grant cycle
      rand_d   = lfsr_q;
      if (r_rand_q) begin
         rd_sel = rand_q;
      end
`endif

      // Outside a CPU read phase the last read value is replayed, which keeps
      // DI stable while the core sits at RDY=0.
      cpu_din = r_cpurd_q ? rd_sel : hold_q;
      hold_d  = cpu_din;

      stall_d = stall_q;
      if (screen_read_en && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_render_q <= 1'b0;
         r_cpurd_q  <= 1'b0;
         r_oob_q    <= 1'b0;
         hold_q     <= 8'h00;
         stall_q    <= 16'h0000;
`ifdef RANDOM_REG_EN
         r_rand_q   <= 1'b0;
         lfsr_q     <= 8'h01;
         rand_q     <= 8'h00;
`endif
      end else begin
         r_render_q <= r_render_d;
         r_cpurd_q  <= r_cpurd_d;
         r_oob_q    <= r_oob_d;
         hold_q     <= hold_d;
         stall_q    <= stall_d;
`ifdef RANDOM_REG_EN
         r_rand_q   <= r_rand_d;
         lfsr_q     <= lfsr_d;
         rand_q     <= rand_d;
`endif
      end
   end

endmodule

// File: tb/tb_screen_mem_arbiter.sv
module tb_screen_mem_arbiter;

   localparam int AW = 11;

   logic          clk;
   logic          reset;
   logic          screen_read_en;
   logic [AW-1:0] screen_read_addr;
   logic [7:0]    screen_read_data;
   logic          screen_read_valid;
   logic [15:0]   cpu_addr;
   logic          cpu_we;
   logic [7:0]    cpu_dout;
   logic [7:0]    cpu_din;
   logic          cpu_rdy;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [7:0]    ram_wdata;
   logic [7:0]    ram_rdata;
   logic [15:0]   stall_cnt;

   int ncmp  = 0;
   int nfail = 0;

   // RAM model: synchronous read, 1-cycle latency, plus a preload port
   logic [7:0]    mem [0:(1<<AW)-1];
   logic          pre_we;
   logic [AW-1:0] pre_addr;
   logic [7:0]    pre_data;

   screen_mem_arbiter #(.ADDR_WIDTH(AW)) dut (
      .clk              (clk),
      .reset            (reset),
      .screen_read_en   (screen_read_en),
      .screen_read_addr (screen_read_addr),
      .screen_read_data (screen_read_data),
      .screen_read_valid(screen_read_valid),
      .cpu_addr         (cpu_addr),
      .cpu_we           (cpu_we),
      .cpu_dout         (cpu_dout),
      .cpu_din          (cpu_din),
      .cpu_rdy          (cpu_rdy),
      .ram_addr         (ram_addr),
      .ram_we           (ram_we),
      .ram_wdata        (ram_wdata),
      .ram_rdata        (ram_rdata),
      .stall_cnt        (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      step();
      pre_we   = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset            = 1'b1;
      screen_read_en   = 1'b0;
      screen_read_addr = '0;
      cpu_addr         = 16'h0100;
      cpu_we           = 1'b1;
      cpu_dout         = 8'hAA;
      pre_we           = 1'b0;
      pre_addr         = '0;
      pre_data         = 8'h00;
      #2;

      // Reset state (CPU write attempted under reset must not reach RAM)
      check("rst_rdy",   cpu_rdy, 0);
      check("rst_we",    ram_we, 0);
      check("rst_valid", screen_read_valid, 0);
      check("rst_stall", stall_cnt, 0);
      check("rst_din",   cpu_din, 8'h00);

      preload(11'h200, 8'h5A);
      preload(11'h210, 8'h11);
      preload(11'h300, 8'h00);
      preload(11'h234, 8'h44);
      preload(11'h0FE, 8'h9C);
      cpu_we = 1'b0;

      // Release reset; test 1: CPU read of 0x0200
      reset    = 1'b0;
      cpu_addr = 16'h0200;
      #1;
      check("t1_din_pre", cpu_din, 8'h00);
      check("t1_rdy",     cpu_rdy, 1);
      check("t1_addr",    ram_addr, 11'h200);
      step();
      check("t1_din",     cpu_din, 8'h5A);

      // Test 2: render reads 0x210 for 3 cycles, CPU stalled
      screen_read_en   = 1'b1;
      screen_read_addr = 11'h210;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t2_rdy",   cpu_rdy, 0);
         check("t2_raddr", ram_addr, 11'h210);
         step();
         check("t2_valid", screen_read_valid, 1);
         check("t2_data",  screen_read_data, 8'h11);
         check("t2_din",   cpu_din, 8'h5A);
      end

      // Test 3: CPU write issued while render holds the port
      cpu_addr = 16'h0300;
      cpu_we   = 1'b1;
      cpu_dout = 8'h33;
      #1;
      check("t3_we_stalled", ram_we, 0);
      step();
      screen_read_en = 1'b0;
      #1;
      check("t3_we",    ram_we, 1);
      check("t3_addr",  ram_addr, 11'h300);
      check("t3_wdata", ram_wdata, 8'h33);
      check("t3_din",   cpu_din, 8'h5A);
      step();
      check("t3_valid_off", screen_read_valid, 0);
      cpu_we = 1'b0;
      step();
      check("t3_readback", cpu_din, 8'h33);

      // Test 4: out-of-RAM read and write
      cpu_addr = 16'h1234;
      step();
      check("t4_oob_din", cpu_din, 8'hFF);
      cpu_we   = 1'b1;
      cpu_dout = 8'h77;
      #1;
      check("t4_oob_we", ram_we, 0);
      step();
      check("t4_ram_kept", mem[11'h234], 8'h44);
      check("t4_din_hold", cpu_din, 8'hFF);
      cpu_we = 1'b0;

      // Test 5: stall counter so far, then saturation
      check("t5_stall_so_far", stall_cnt, 16'd4);
      screen_read_en = 1'b1;
      repeat (65600) step();
      check("t5_stall_sat", stall_cnt, 16'hFFFF);
      reset = 1'b1;
      #1;
      check("t5_rst_stall", stall_cnt, 16'h0000);
      check("t5_rst_valid", screen_read_valid, 0);
      check("t5_rst_din",   cpu_din, 8'h00);
      check("t5_rst_rdy",   cpu_rdy, 0);
      screen_read_en = 1'b0;
      step();

      // Test 6: reads of 0x00FE
      reset    = 1'b0;
      cpu_addr = 16'h00FE;
`ifdef RANDOM_REG_EN
      begin
         logic [7:0] exp_rand [0:7];
         exp_rand = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h21, 8'h43, 8'h86};
         for (int i = 0; i < 8; i++) begin
            step();
            check("t6_rand", cpu_din, exp_rand[i]);
         end
      end
`else
      step();
      check("t6_ram_fe", cpu_din, 8'h9C);
      step();
      check("t6_ram_fe2", cpu_din, 8'h9C);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
